// File: rtl/ret_stack_if.sv
// Call/return port bundle for the hardware return-address stack.
// The master side (CPU control) drives the requests; the slave side (stack) reports its state.
interface ret_stack_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             enable;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output enable, push, pop, d, clr_err,
    input  q, empty, full, count, overflow, underflow
  );

  modport slave (
    input  enable, push, pop, d, clr_err,
    output q, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/ret_stack.sv
// Return-address stack between the PC adder and the PC mux.
// The top entry is read combinationally, so a RET uses it as next PC in the same cycle it pops.
module ret_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  ret_stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [CW-1:0]    sp_m1;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             is_empty;
  logic             is_full;
  logic             ovf_q;
  logic             unf_q;

  assign sp_m1    = sp - CW'(1);
  assign wr_idx   = sp[AW-1:0];
  assign top_idx  = sp_m1[AW-1:0];
  assign is_empty = (sp == CW'(0));
  assign is_full  = (sp == CW'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      sp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.enable) begin
      // clear first so an error raised in the same cycle takes precedence
      if (bus.clr_err) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      unique case ({bus.push, bus.pop})
        2'b10: begin
          if (!is_full) begin
            mem[wr_idx] <= bus.d;
            sp          <= sp + CW'(1);
          end else begin
            ovf_q <= 1'b1;
          end
        end
        2'b01: begin
          if (!is_empty) begin
            sp <= sp_m1;
          end else begin
            unf_q <= 1'b1;
          end
        end
        2'b11: begin
          if (!is_empty) begin
            mem[top_idx] <= bus.d;
          end else begin
            mem[0] <= bus.d;
            sp     <= CW'(1);
            unf_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.q         = is_empty ? '0 : mem[top_idx];
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.count     = sp;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
